mem_stack: RTL and testbench

MEM_STACK -- requirements
Module: mem_stack

---
 rtl/mem_stack_pkg.sv | 44 ++++
 rtl/mem_stack_regfile.sv | 39 +++
 rtl/mem_stack.sv | 149 ++++++++++++++
 tb/tb_mem_stack.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_stack_pkg.sv
// mem_stack_pkg -- shared definitions for the MEM-bus stack peripheral.
//
// Holds the default geometry, the statusOut bit map and the strobe decode
// used by mem_stack. Imported by every file of the block so the bit
// positions and defaults live in exactly one place.
package mem_stack_pkg;

  // Default geometry.
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 16;

  // statusOut bit positions.
  localparam int STAT_OVF   = 15;
  localparam int STAT_UNF   = 14;
  localparam int STAT_FULL  = 13;
  localparam int STAT_EMPTY = 12;
  localparam int STAT_CNT_W = 5;   // count field occupies statusOut[4:0]

  // Decoded bus operation for one cycle.
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_t;

  // write and read together on a selected cycle mean "replace top".
  function automatic stack_op_t decode_op(input logic sel,
                                          input logic write,
                                          input logic read);
    stack_op_t op;
    op = OP_NONE;
    if (sel) begin
      case ({write, read})
        2'b10:   op = OP_PUSH;
        2'b01:   op = OP_POP;
        2'b11:   op = OP_REPLACE;
        default: op = OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_stack_regfile.sv
// stack_regfile -- storage for mem_stack.
//
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. Entries carry no reset; their content is
// undefined until written.
//
// Ports:
//   clk    in   clock, write happens on the rising edge
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  combinational read of entry raddr
module stack_regfile
  import mem_stack_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stack.sv
// mem_stack -- LIFO stack peripheral on the MEM bus.
//
// Control, pointer and sticky flags for a DEPTH-entry stack; storage lives
// in stack_regfile. Every output comes straight from a register (statusOut
// full/empty are decoded from the registered count only), so there is no
// combinational path from any input to any output.
//
// Ports:
//   CLK        in   system clock, all state changes on the rising edge
//   RESET_N    in   asynchronous active-low reset
//   sel        in   peripheral select, qualifies write/read
//   write      in   push strobe
//   read       in   pop strobe (write & read = replace top)
//   clear      in   synchronous flush + flag clear, ignores sel
//   dataIn     in   push / replace data
//   dataOut    out  registered top-of-stack, 0 when empty
//   statusOut  out  {overflow, underflow, full, empty, 7'b0, count[4:0]}
module mem_stack
  import mem_stack_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             sel,
  input  logic             write,
  input  logic             read,
  input  logic             clear,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic [15:0]      statusOut
);

  localparam int CW = $clog2(DEPTH + 1);  // count holds 0..DEPTH
  localparam int IW = $clog2(DEPTH);      // storage index

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic             full;
  logic             empty;
  stack_op_t        op;

  logic             mem_we;
  logic [IW-1:0]    mem_waddr;
  logic [IW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign op    = decode_op(sel, write, read);

  // The read port always looks at the entry just below the current top:
  // that is what becomes visible after a pop.
  assign mem_raddr = IW'(count_reg - CW'(2));

  stack_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_regfile (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (dataIn),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    count_next     = count_reg;
    data_next      = data_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    mem_we         = 1'b0;
    mem_waddr      = IW'(count_reg);

    if (clear) begin
      count_next     = '0;
      data_next      = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (full) begin
            overflow_next = 1'b1;
          end else begin
            mem_we     = 1'b1;
            mem_waddr  = IW'(count_reg);
            count_next = count_reg + CW'(1);
            data_next  = dataIn;
          end
        end
        OP_POP: begin
          if (empty) begin
            underflow_next = 1'b1;
          end else begin
            count_next = count_reg - CW'(1);
            // Popping the last entry exposes nothing, so show 0.
            data_next  = (count_reg == CW'(1)) ? '0 : mem_rdata;
          end
        end
        OP_REPLACE: begin
          mem_we    = 1'b1;
          data_next = dataIn;
          if (empty) begin
            // Nothing to replace: behaves as a push (never full here).
            mem_waddr  = IW'(count_reg);
            count_next = count_reg + CW'(1);
          end else begin
            mem_waddr  = IW'(count_reg - CW'(1));
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_reg     <= '0;
      data_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      data_reg      <= data_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  always_comb begin
    statusOut               = '0;
    statusOut[STAT_OVF]     = overflow_reg;
    statusOut[STAT_UNF]     = underflow_reg;
    statusOut[STAT_FULL]    = full;
    statusOut[STAT_EMPTY]   = empty;
    statusOut[STAT_CNT_W-1:0] = STAT_CNT_W'(count_reg);
  end

  assign dataOut = data_reg;

endmodule

// File: tb/tb_mem_stack.sv
// tb_mem_stack -- self-checking bench for mem_stack (default 16 x 16).
module tb_mem_stack;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        sel = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] dataIn = '0;
  logic [15:0] dataOut;
  logic [15:0] statusOut;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stack dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .sel       (sel),
    .write     (write),
    .read      (read),
    .clear     (clear),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .statusOut (statusOut)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic [15:0] status;
    string       name;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        s, w, r, c;
    logic [15:0] din;
    logic [15:0] exp_data;
    logic [15:0] exp_stat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: empty queue at check");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".data"}, dataOut, e.data);
    chk({e.name, ".status"}, statusOut, e.status);
    $display("txn %-14s dataOut=%h statusOut=%h", e.name, dataOut, statusOut);
  endtask

  // Drive one cycle of strobes, record the expectation, sample after the edge.
  task automatic step(input logic s, input logic w, input logic r, input logic c,
                      input logic [15:0] din, input logic [15:0] ed,
                      input logic [15:0] es, input string name);
    exp_t e;
    sel = s; write = w; read = r; clear = c; dataIn = din;
    e.data = ed; e.status = es; e.name = name;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    sel = 1'b0; write = 1'b0; read = 1'b0; clear = 1'b0;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got running required finished");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //            sel w  r  clr din       data      status
    vecs[0]  = '{1, 1, 0, 0, 16'hA001, 16'hA001, 16'h0001};
    vecs[1]  = '{1, 1, 0, 0, 16'hB002, 16'hB002, 16'h0002};
    vecs[2]  = '{1, 0, 1, 0, 16'h0000, 16'hA001, 16'h0001};
    vecs[3]  = '{1, 0, 1, 0, 16'h0000, 16'h0000, 16'h1000};
    vecs[4]  = '{1, 0, 1, 0, 16'h0000, 16'h0000, 16'h5000}; // underflow
    vecs[5]  = '{0, 0, 0, 1, 16'h0000, 16'h0000, 16'h1000}; // clear
    vecs[6]  = '{1, 1, 0, 0, 16'h1234, 16'h1234, 16'h0001};
    vecs[7]  = '{1, 1, 1, 0, 16'h5678, 16'h5678, 16'h0001}; // replace
    vecs[8]  = '{1, 0, 1, 0, 16'h0000, 16'h0000, 16'h1000};
    vecs[9]  = '{0, 1, 0, 0, 16'h9999, 16'h0000, 16'h1000}; // sel low
    vecs[10] = '{0, 0, 1, 0, 16'h0000, 16'h0000, 16'h1000};
    vecs[11] = '{1, 1, 0, 0, 16'h4444, 16'h4444, 16'h0001};
    vecs[12] = '{0, 1, 1, 0, 16'h7777, 16'h4444, 16'h0001};
    vecs[13] = '{1, 1, 0, 1, 16'h5555, 16'h0000, 16'h1000}; // clear wins
    vecs[14] = '{1, 1, 1, 0, 16'h6666, 16'h6666, 16'h0001}; // replace empty
    vecs[15] = '{0, 0, 0, 0, 16'h0000, 16'h6666, 16'h0001};
    vecs[16] = '{1, 0, 1, 0, 16'h0000, 16'h0000, 16'h1000};

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.data", dataOut, 16'h0000);
    chk("reset.status", statusOut, 16'h1000);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].din,
           vecs[i].exp_data, vecs[i].exp_stat, $sformatf("vec%0d", i));
    end

    // Fill to full, then one push too many.
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 0, 16'(i), 16'(i),
           (i == 15) ? 16'h2010 : 16'(i + 1), $sformatf("fill%0d", i));
    end
    step(1, 1, 0, 0, 16'hFFFF, 16'h000F, 16'hA010, "overflow");
    // LIFO order on the way down; overflow stays sticky.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 16'h0000, 16'(14 - i), 16'(16'h8000 + 15 - i),
           $sformatf("drain%0d", i));
    end
    step(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h1000, "clear2");

    // Reset pulled mid-operation between two pushes.
    step(1, 1, 0, 0, 16'h1111, 16'h1111, 16'h0001, "pre_rst");
    sel = 1'b1; write = 1'b1; dataIn = 16'h2222;
    #2;
    RESET_N = 1'b0;
    #1;
    e.data = 16'h0000; e.status = 16'h1000; e.name = "in_rst";
    sb.push_back(e);
    check_out();
    @(posedge CLK);
    #1;
    sel = 1'b0; write = 1'b0;
    e.data = 16'h0000; e.status = 16'h1000; e.name = "hold_rst";
    sb.push_back(e);
    check_out();
    RESET_N = 1'b1;
    step(1, 1, 0, 0, 16'h3333, 16'h3333, 16'h0001, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
